spi_regfile_slave: RTL and testbench
====================================

SPI_REGFILE_SLAVE -- requirements
Module: spi_regfile_slave

Interface
REQ-001 Parameter ADDR_W, default 7, sets the register address width; depth is DEPTH = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 32, sets the register data width (legal range 8..64).
REQ-003 Parameter CPOL, default 0, sets the SPI clock idle level.
REQ-004 Parameter CPHA, default 0, selects the sampling edge: 0 = leading edge, 1 = trailing edge.
REQ-005 Parameter BURST_EN, default 1, enables address auto-increment within one CS frame.
REQ-006 clk  in  1  system clock; the block uses one clock only.
REQ-007 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-008 sclk  in  1  SPI clock from master; asynchronous to clk.
REQ-009 cs_n  in  1  chip select; active-low; asynchronous.
REQ-010 mosi  in  1  master-out data; asynchronous.
REQ-011 miso  out  1  slave-out data; driven 0 whenever not shifting read data.
REQ-012 wr_stb  out  1  one-clk pulse on every committed register write.
REQ-013 wr_addr  out  ADDR_W  address of the committed write; held until the next wr_stb.
REQ-014 wr_data  out  DATA_W  data of the committed write; held until the next wr_stb.
REQ-015 frame_err  out  1  one-clk pulse when a frame ends on a partial word.
REQ-016 busy  out  1  high while a frame is active (synchronised cs_n low).

Function
REQ-017 sclk, cs_n and mosi SHALL each pass through a 2-flop synchroniser before use; sclk edges are detected on the synchronised value; sclk frequency SHALL be at most clk/8.
REQ-018 Leading edge SHALL be the idle-to-active sclk transition per CPOL; sample edge = leading if CPHA=0, else trailing; the shift edge is the opposite edge.
REQ-019 Frame format, MSB first: 1 R/W bit (1 = write), then ADDR_W address bits, then one or more DATA_W data words.
REQ-020 FSM states: IDLE, CMD, DATA; IDLE->CMD on synchronised cs_n falling; CMD->DATA after 1+ADDR_W samples; any state->IDLE on synchronised cs_n rising.
REQ-021 Write: on the sample of each word's last data bit, reg[addr] <= word; wr_stb pulses within 2 clk of that sample, with wr_addr/wr_data valid.
REQ-022 Read: reg[addr] SHALL be loaded into the output shifter when CMD completes; for CPHA=0 the MSB is driven on the shift edge following the last address sample; for CPHA=1 it is driven on the first DATA-phase shift edge.
REQ-023 Burst (BURST_EN=1): after each full word with cs_n still low, addr <= addr+1, wrapping DEPTH-1 -> 0; reads reload the shifter from the new address; BURST_EN=0: extra bits are ignored, miso = 0.
REQ-024 cs_n rising with a partial word (CMD incomplete, or 1..DATA_W-1 data bits) SHALL discard that word, perform no write, and pulse frame_err; a write frame ending exactly on a word boundary raises no error.
REQ-025 During write frames, and whenever cs_n is high, miso SHALL be 0.
REQ-026 sclk edges while cs_n is high SHALL be ignored.

Reset
REQ-027 Asynchronous assert of rst_n SHALL force state IDLE; miso, wr_stb, frame_err and busy to 0; wr_addr and wr_data to 0; all counters and shifters to 0.
REQ-028 Register-array contents SHALL NOT be reset; reset mid-frame SHALL abort the frame with no write and no frame_err.
REQ-029 Synchroniser flops reset to: cs_n stage 1, sclk stage = CPOL, mosi stage 0.

Structure
REQ-030 Shared package spi_pkg SHALL hold the FSM state encoding, mode constants (CPOL/CPHA combinations) and the R/W bit encoding.
REQ-031 One sub-module spi_sync_edge (2-flop synchroniser plus rise/fall pulse) SHALL be instantiated for sclk, cs_n and mosi.

Verification
REQ-032 Mode 0, defaults: write addr 0x05 data 0xDEADBEEF -> wr_stb once, wr_addr=0x05, wr_data=0xDEADBEEF; then read 0x05 -> miso returns 0xDEADBEEF MSB first.
REQ-033 Modes 1, 2, 3 each: same write/read pair -> identical data returned, sampled on the correct edge.
REQ-034 Burst write at addr 0x7F with 3 words A,B,C -> wr_stb x3 at addresses 0x7F, 0x00, 0x01; burst read from 0x7F returns A,B,C.
REQ-035 cs_n raised after 20 data bits of a write to 0x10 -> frame_err pulse, no wr_stb, reg[0x10] unchanged on readback.
REQ-036 rst_n asserted mid-read frame -> miso=0 and busy=0 immediately; the next full frame operates normally.
REQ-037 ADDR_W=4, DATA_W=16 instance: write 0xA5A5 to addr 0xF, read back -> 0xA5A5; burst increments wrap 0xF -> 0x0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file slave: FSM encoding, SPI mode
// constants ({CPOL,CPHA}) and the command R/W bit encoding.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;
    localparam logic [1:0] MODE_2 = 2'b10;
    localparam logic [1:0] MODE_3 = 2'b11;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // True when the sample edge of the given mode is a rising sclk edge.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        logic res;
        res = 1'b0;
        unique case (mode)
            MODE_0, MODE_3: res = 1'b1;
            MODE_1, MODE_2: res = 1'b0;
            default:        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus registered rise/fall
// pulses; level, rise and fall are time-aligned.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= RST_VAL;
            s2    <= RST_VAL;
            level <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            level <= s2;
            rise  <= s2 & ~level;
            fall  <= ~s2 & level;
        end
    end

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI slave giving a master read/write access to a DEPTH x DATA_W register
// array, with optional burst auto-increment. All SPI pins are oversampled by clk.
module spi_regfile_slave
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CPOL     = 0,
    parameter int unsigned CPHA     = 0,
    parameter int unsigned BURST_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned CMD_BITS = 1 + ADDR_W;
    localparam int unsigned MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
    localparam int unsigned CNT_W    = $clog2(MAX_BITS);
    localparam logic [1:0]  MODE     = {1'(CPOL), 1'(CPHA)};
    localparam logic        SAMPLE_RISE = sample_on_rise(MODE);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'(CPOL))) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .raw(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .raw(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .raw(mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    logic [DATA_W-1:0] regs [DEPTH];

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [CMD_BITS-1:0] cmd_sh, cmd_sh_nxt, cmd_word;
    logic [DATA_W-1:0]   data_sh, data_sh_nxt, data_word;
    logic [DATA_W-1:0]   rd_sh, rd_sh_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt, addr_inc;
    logic                rw, rw_nxt;
    logic                word_done, word_done_nxt;
    logic                miso_nxt, wr_stb_nxt, frame_err_nxt, busy_nxt;
    logic [ADDR_W-1:0]   wr_addr_nxt;
    logic [DATA_W-1:0]   wr_data_nxt;
    logic                we;
    logic                sample_p, shift_p;

    // sclk edges only count while the synchronised chip select is active
    assign sample_p  = ~cs_level & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign shift_p   = ~cs_level & (SAMPLE_RISE ? sclk_fall : sclk_rise);
    assign cmd_word  = {cmd_sh[CMD_BITS-2:0], mosi_s};
    assign data_word = {data_sh[DATA_W-2:0], mosi_s};
    assign addr_inc  = addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                if (cs_rise)                              state_nxt = ST_IDLE;
                else if (sample_p && bit_cnt == CMD_LAST) state_nxt = ST_DATA;
            end
            ST_DATA: if (cs_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_nxt   = bit_cnt;
        cmd_sh_nxt    = cmd_sh;
        data_sh_nxt   = data_sh;
        rd_sh_nxt     = rd_sh;
        addr_nxt      = addr;
        rw_nxt        = rw;
        word_done_nxt = word_done;
        miso_nxt      = miso;
        wr_stb_nxt    = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        frame_err_nxt = 1'b0;
        busy_nxt      = (state_nxt != ST_IDLE);
        we            = 1'b0;
        unique case (state)
            ST_IDLE: begin
                bit_cnt_nxt   = '0;
                miso_nxt      = 1'b0;
                word_done_nxt = 1'b0;
                if (cs_fall) begin
                    cmd_sh_nxt  = '0;
                    data_sh_nxt = '0;
                    rd_sh_nxt   = '0;
                end
            end
            ST_CMD: begin
                if (cs_rise) begin
                    frame_err_nxt = 1'b1;
                    bit_cnt_nxt   = '0;
                end else if (sample_p) begin
                    cmd_sh_nxt = cmd_word;
                    if (bit_cnt == CMD_LAST) begin
                        bit_cnt_nxt = '0;
                        rw_nxt      = cmd_word[ADDR_W];
                        addr_nxt    = cmd_word[ADDR_W-1:0];
                        rd_sh_nxt   = (cmd_word[ADDR_W] == RW_READ) ?
                                      regs[cmd_word[ADDR_W-1:0]] : '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    frame_err_nxt = (bit_cnt != '0) && !word_done;
                    bit_cnt_nxt   = '0;
                    miso_nxt      = 1'b0;
                    rd_sh_nxt     = '0;
                end else begin
                    if (shift_p && rw == RW_READ) begin
                        miso_nxt  = rd_sh[DATA_W-1];
                        rd_sh_nxt = rd_sh << 1;
                    end
                    if (sample_p && !word_done) begin
                        data_sh_nxt = data_word;
                        if (bit_cnt == WORD_LAST) begin
                            bit_cnt_nxt = '0;
                            if (rw == RW_WRITE) begin
                                we          = 1'b1;
                                wr_stb_nxt  = 1'b1;
                                wr_addr_nxt = addr;
                                wr_data_nxt = data_word;
                            end
                            // without burst the rest of the frame is ignored
                            if (BURST_EN != 0) begin
                                addr_nxt = addr_inc;
                                if (rw == RW_READ) rd_sh_nxt = regs[addr_inc];
                            end else begin
                                word_done_nxt = 1'b1;
                                rd_sh_nxt     = '0;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            cmd_sh    <= '0;
            data_sh   <= '0;
            rd_sh     <= '0;
            addr      <= '0;
            rw        <= RW_READ;
            word_done <= 1'b0;
            miso      <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            cmd_sh    <= cmd_sh_nxt;
            data_sh   <= data_sh_nxt;
            rd_sh     <= rd_sh_nxt;
            addr      <= addr_nxt;
            rw        <= rw_nxt;
            word_done <= word_done_nxt;
            miso      <= miso_nxt;
            wr_stb    <= wr_stb_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            frame_err <= frame_err_nxt;
            busy      <= busy_nxt;
        end
    end

    // Register array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (we) regs[addr] <= data_word;
    end

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Bench for spi_regfile_slave: four default-size instances (SPI modes 0..3) and
// one ADDR_W=4/DATA_W=16 instance, driven by a bit-level SPI master task.
module tb_spi_regfile_slave;

    localparam int HALF = 6;  // clk cycles per sclk half period

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  sclk = 5'b01100;
    logic [4:0]  cs_n = 5'b11111;
    logic [4:0]  mosi = 5'b00000;
    logic [4:0]  miso, wr_stb, frame_err, busy;
    logic [6:0]  wa [4];
    logic [31:0] wd [4];
    logic [3:0]  wa_s;
    logic [15:0] wd_s;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_regfile_slave #(.CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .clk(clk), .rst_n(rst_n), .sclk(sclk[g]), .cs_n(cs_n[g]),
            .mosi(mosi[g]), .miso(miso[g]), .wr_stb(wr_stb[g]),
            .wr_addr(wa[g]), .wr_data(wd[g]), .frame_err(frame_err[g]),
            .busy(busy[g])
        );
    end

    spi_regfile_slave #(.ADDR_W(4), .DATA_W(16)) u_small (
        .clk(clk), .rst_n(rst_n), .sclk(sclk[4]), .cs_n(cs_n[4]),
        .mosi(mosi[4]), .miso(miso[4]), .wr_stb(wr_stb[4]),
        .wr_addr(wa_s), .wr_data(wd_s), .frame_err(frame_err[4]),
        .busy(busy[4])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int aw(input int i);  return (i == 4) ? 4 : 7;  endfunction
    function automatic int dw(input int i);  return (i == 4) ? 16 : 32; endfunction
    function automatic logic cpol(input int i); return (i == 2 || i == 3); endfunction
    function automatic logic cpha(input int i); return (i == 1 || i == 3); endfunction
    function automatic logic [63:0] mask(input int i);
        return (i == 4) ? 64'hFFFF : 64'hFFFF_FFFF;
    endfunction

    // Write-strobe and frame-error monitor, sampled on the falling clk edge.
    int          wr_cnt  [5] = '{default: 0};
    int          err_cnt [5] = '{default: 0};
    logic [63:0] cap_a [5][16];
    logic [63:0] cap_d [5][16];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_stb[i]) begin
                cap_a[i][wr_cnt[i] % 16] <= 64'(wa[i]);
                cap_d[i][wr_cnt[i] % 16] <= 64'(wd[i]);
                wr_cnt[i] <= wr_cnt[i] + 1;
            end
        end
        if (wr_stb[4]) begin
            cap_a[4][wr_cnt[4] % 16] <= 64'(wa_s);
            cap_d[4][wr_cnt[4] % 16] <= 64'(wd_s);
            wr_cnt[4] <= wr_cnt[4] + 1;
        end
        for (int i = 0; i < 5; i++) if (frame_err[i]) err_cnt[i] <= err_cnt[i] + 1;
    end

    logic [63:0] mdl [5][128];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit-level SPI master; tx/rx are MSB-first in the low n bits.
    task automatic spi_xfer(input int i, input logic [255:0] tx, input int n,
                            input bit keep_cs, output logic [255:0] rx);
        rx = '0;
        @(negedge clk);
        cs_n[i] = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < n; k++) begin
            if (!cpha(i)) begin
                mosi[i] = tx[n-1-k];
                wait_clk(HALF);
                sclk[i] = ~cpol(i);
                rx[n-1-k] = miso[i];
                wait_clk(HALF);
                sclk[i] = cpol(i);
            end else begin
                sclk[i] = ~cpol(i);
                mosi[i] = tx[n-1-k];
                wait_clk(HALF);
                sclk[i] = cpol(i);
                rx[n-1-k] = miso[i];
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
        if (!keep_cs) begin
            cs_n[i] = 1'b1;
            mosi[i] = 1'b0;
            wait_clk(4 * HALF);
        end
    endtask

    task automatic do_write(input int i, input int addr, input int nw,
                            input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2);
        logic [63:0]  w [3];
        logic [255:0] tx, rx;
        int c0, e0, a;
        w[0] = w0 & mask(i);
        w[1] = w1 & mask(i);
        w[2] = w2 & mask(i);
        tx = 256'(1);
        tx = (tx << aw(i)) | 256'(addr);
        for (int k = 0; k < nw; k++) tx = (tx << dw(i)) | 256'(w[k]);
        c0 = wr_cnt[i];
        e0 = err_cnt[i];
        spi_xfer(i, tx, 1 + aw(i) + dw(i) * nw, 1'b0, rx);
        check($sformatf("wr_count[%0d]", i), 64'(wr_cnt[i] - c0), 64'(nw));
        for (int k = 0; k < nw; k++) begin
            a = (addr + k) % (1 << aw(i));
            check($sformatf("wr_addr[%0d]", i), cap_a[i][(c0 + k) % 16], 64'(a));
            check($sformatf("wr_data[%0d]", i), cap_d[i][(c0 + k) % 16], w[k]);
            mdl[i][a] = w[k];
        end
        check($sformatf("wr_noerr[%0d]", i), 64'(err_cnt[i] - e0), 64'(0));
        check($sformatf("wr_miso_zero[%0d]", i), 64'(rx == '0), 64'(1));
    endtask

    task automatic do_read(input int i, input int addr, input int nw);
        logic [255:0] tx, rx;
        logic [63:0]  got;
        int c0, e0;
        tx = 256'(addr) << (dw(i) * nw);
        c0 = wr_cnt[i];
        e0 = err_cnt[i];
        spi_xfer(i, tx, 1 + aw(i) + dw(i) * nw, 1'b0, rx);
        for (int k = 0; k < nw; k++) begin
            got = 64'(rx >> (dw(i) * (nw - 1 - k))) & mask(i);
            check($sformatf("rd_data[%0d]", i), got, mdl[i][(addr + k) % (1 << aw(i))]);
        end
        check($sformatf("rd_cmd_miso_zero[%0d]", i), 64'(rx >> (dw(i) * nw)), 64'(0));
        check($sformatf("rd_no_side_effect[%0d]", i),
              64'((wr_cnt[i] - c0) + (err_cnt[i] - e0)), 64'(0));
    endtask

    initial begin
        logic [255:0] tx, rx;
        int e0, c0, a, nw;

        wait_clk(5);
        check("rst_miso", 64'(miso), 64'(0));
        check("rst_wr_stb", 64'(wr_stb), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_wr_addr", 64'(wa[0]), 64'(0));
        check("rst_wr_data", 64'(wd[0]), 64'(0));
        check("rst_wr_data_small", 64'(wd_s), 64'(0));
        rst_n = 1'b1;
        wait_clk(5);

        // Each mode: directed pair, then one randomised burst pair
        for (int i = 0; i < 4; i++) begin
            do_write(i, 'h05, 1, 64'hDEAD_BEEF, 64'h0, 64'h0);
            do_read(i, 'h05, 1);
            a  = int'($urandom_range(0, 127));
            nw = int'($urandom_range(1, 3));
            do_write(i, a, nw, 64'($urandom), 64'($urandom), 64'($urandom));
            do_read(i, a, nw);
        end

        do_write(0, 'h7F, 3, 64'h1111_AAAA, 64'h2222_BBBB, 64'h3333_CCCC);
        do_read(0, 'h7F, 3);

        // Write frame cut off after 20 data bits
        do_write(0, 'h10, 1, 64'($urandom), 64'h0, 64'h0);
        tx = (((256'(1) << 7) | 256'('h10)) << 20) | 256'($urandom_range(0, 'hFFFFF));
        c0 = wr_cnt[0];
        e0 = err_cnt[0];
        spi_xfer(0, tx, 28, 1'b0, rx);
        check("partial_frame_err", 64'(err_cnt[0] - e0), 64'(1));
        check("partial_no_wr", 64'(wr_cnt[0] - c0), 64'(0));
        do_read(0, 'h10, 1);

        // Reset during a mode-0 read of 0x05 (DEADBEEF): bit 28 is on miso
        e0 = err_cnt[0];
        c0 = wr_cnt[0];
        tx = 256'('h05) << 3;
        spi_xfer(0, tx, 11, 1'b1, rx);
        check("midread_busy", 64'(busy[0]), 64'(1));
        check("midread_miso", 64'(miso[0]), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_miso", 64'(miso[0]), 64'(0));
        check("rst_mid_busy", 64'(busy[0]), 64'(0));
        cs_n[0] = 1'b1;
        mosi[0] = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(10);
        check("rst_mid_no_err", 64'(err_cnt[0] - e0), 64'(0));
        check("rst_mid_no_wr", 64'(wr_cnt[0] - c0), 64'(0));
        do_read(0, 'h05, 1);
        do_write(0, 'h33, 1, 64'($urandom), 64'h0, 64'h0);
        do_read(0, 'h33, 1);

        do_write(4, 'hF, 1, 64'hA5A5, 64'h0, 64'h0);
        do_read(4, 'hF, 1);
        do_write(4, 'hF, 2, 64'($urandom), 64'($urandom), 64'h0);
        do_read(4, 'hF, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
